// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the simple CPU: bus and instruction widths, opcodes, step encoding.
// Latency: none (package only).
// Backpressure: none (package only).
package simple_cpu_pkg;

  localparam int DATA_W = 16;
  localparam int IR_W   = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Control step of the sequencer; T0 is the fetch/idle step.
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit bundle: start request and instruction/immediate in, datapath control strobes out.
// Latency: wires only; all timing is defined by control_unit.
// Backpressure: none; run is a level request sampled by the sequencer in T0.
// Optional: CONTROL_UNIT_ILLEGAL_OP_EN adds the illegal-opcode pulse.
interface control_unit_if;
  import simple_cpu_pkg::*;

  logic              run;
  logic [DATA_W-1:0] din;
  logic              irin;
  logic [7:0]        rin;
  logic [7:0]        rout;
  logic              gout;
  logic              dinout;
  logic              ain;
  logic              gin;
  logic              sub;
  logic              done;
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
  logic              illegal;
`endif

  // Sequencer side: consumes run/din, produces every control strobe.
  modport master (
    input  run, din,
    output irin, rin, rout, gout, dinout, ain, gin, sub, done
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
    , output illegal
`endif
  );

  // Datapath/host side: supplies run/din, observes the control strobes.
  modport slave (
    output run, din,
    input  irin, rin, rout, gout, dinout, ain, gin, sub, done
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
    , input illegal
`endif
  );

endinterface

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero output when disabled.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  // One bit per register index, gated by the enable.
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: captures a 9-bit instruction in T0 and decodes (step, IR) into datapath controls.
// Latency: done 1 cycle after the run edge for mv/mvi/undefined, 3 cycles for add/sub; T0 costs one cycle.
// Backpressure: none; run is only sampled in T0. Macro CONTROL_UNIT_ILLEGAL_OP_EN enables the illegal output.
module control_unit
  import simple_cpu_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  control_unit_if.master bus
);

  step_t           step;
  step_t           step_nxt;
  logic [IR_W-1:0] ir;

  logic [2:0] op;
  logic [7:0] x_oh;
  logic [7:0] y_oh;

  // Raw decode before the reset gate.
  logic irin_c;
  logic rin_x;
  logic rout_x;
  logic rout_y;
  logic gout_c;
  logic dinout_c;
  logic ain_c;
  logic gin_c;
  logic sub_c;
  logic done_c;
  logic illegal_c;

  // Only din[8:0] is captured into IR; the upper bits matter solely for the mvi immediate on the bus.
  logic unused_din;
  assign unused_din = ^bus.din[DATA_W-1:IR_W];

  assign op = ir[8:6];

  // Decoders are disabled under reset so no write enable can leak while reset is held.
  dec3to8 x_dec (
    .en     (~reset),
    .sel    (ir[5:3]),
    .onehot (x_oh)
  );

  dec3to8 y_dec (
    .en     (~reset),
    .sel    (ir[2:0]),
    .onehot (y_oh)
  );

  // Step register; reset aborts any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      step <= T0;
    end else begin
      step <= step_nxt;
    end
  end

  // Instruction register, loaded on the same edge that leaves T0.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir <= '0;
    end else if (irin_c) begin
      ir <= bus.din[IR_W-1:0];
    end
  end

  // Next-step and control decode from (step, IR).
  always_comb begin
    step_nxt  = step;
    irin_c    = 1'b0;
    rin_x     = 1'b0;
    rout_x    = 1'b0;
    rout_y    = 1'b0;
    gout_c    = 1'b0;
    dinout_c  = 1'b0;
    ain_c     = 1'b0;
    gin_c     = 1'b0;
    sub_c     = 1'b0;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    case (step)
      T0: begin
        irin_c = bus.run;
        if (bus.run) begin
          step_nxt = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            rout_y   = 1'b1;
            rin_x    = 1'b1;
            done_c   = 1'b1;
            step_nxt = T0;
          end
          OP_MVI: begin
            dinout_c = 1'b1;
            rin_x    = 1'b1;
            done_c   = 1'b1;
            step_nxt = T0;
          end
          OP_ADD, OP_SUB: begin
            rout_x   = 1'b1;
            ain_c    = 1'b1;
            step_nxt = T2;
          end
          default: begin
            // 1xx opcodes: no bus or register activity, just finish.
            done_c    = 1'b1;
            illegal_c = 1'b1;
            step_nxt  = T0;
          end
        endcase
      end
      T2: begin
        // Only add/sub reach T2, so the subtract flag is the opcode LSB check.
        rout_y   = 1'b1;
        gin_c    = 1'b1;
        sub_c    = (op == OP_SUB);
        step_nxt = T3;
      end
      T3: begin
        gout_c   = 1'b1;
        rin_x    = 1'b1;
        done_c   = 1'b1;
        step_nxt = T0;
      end
      default: begin
        step_nxt = T0;
      end
    endcase
  end

  // Output stage: everything forced low while reset is held.
  always_comb begin
    bus.irin   = ~reset & irin_c;
    bus.rin    = rin_x ? x_oh : 8'h00;
    bus.rout   = rout_x ? x_oh : (rout_y ? y_oh : 8'h00);
    bus.gout   = ~reset & gout_c;
    bus.dinout = ~reset & dinout_c;
    bus.ain    = ~reset & ain_c;
    bus.gin    = ~reset & gin_c;
    bus.sub    = ~reset & sub_c;
    bus.done   = ~reset & done_c;
  end

`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
  assign bus.illegal = ~reset & illegal_c;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_c;
`endif

endmodule
